// File: rtl/sio_target_regs_if.sv
// Write-word / readback link between sio_target and its register bank.
interface sio_target_regs_if;
  logic        wvalid;
  logic [39:0] wdata;
  logic [31:0] rdata;

  modport master (output wvalid, output wdata, input rdata);
  modport slave  (input wvalid, input wdata, output rdata);
endinterface

// File: rtl/sio_target_regs.sv
// Register bank behind sio_target: decodes 40-bit command words into control registers,
// status readback, an error counter and a link watchdog that restores defaults on idle.
module sio_target_regs #(
  parameter int                  NREG     = 8,
  parameter int                  TIMEOUT  = 4095,
  parameter logic [NREG*32-1:0]  DEFAULTS = '0
) (
  input  logic                 c,
  input  logic                 r,
  sio_target_regs_if.slave     bus,
  input  logic [32*NREG-1:0]   ext,
  output logic [32*NREG-1:0]   q,
  output logic [NREG-1:0]      wstrobe,
  output logic                 link_up
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic {DOWN = 1'b0, UP = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    err_cnt;
  logic [31:0]   rdata_r;

  logic [1:0]    cmd;
  logic [5:0]    addr;
  logic [31:0]   data;
  logic [NREG-1:0] sel;
  logic          addr_hit;
  logic [31:0]   ext_word;
  logic [31:0]   rd_word;
  logic [7:0]    err_wr;
  logic [7:0]    err_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] e);
    return (e == 8'hFF) ? e : e + 8'd1;
  endfunction

  assign cmd       = bus.wdata[39:38];
  assign addr      = bus.wdata[37:32];
  assign data      = bus.wdata[31:0];
  assign bus.rdata = rdata_r;

  always_comb begin
    sel      = '0;
    ext_word = '0;
    for (int k = 0; k < NREG; k++) begin
      sel[k] = (addr == 6'(k));
      if (sel[k]) ext_word = ext[32*k +: 32];
    end
    addr_hit = |sel;
  end

  // The write half acts first, so a combined write+read observes the written state.
  always_comb begin
    err_wr = err_cnt;
    if (cmd[0] && !addr_hit)
      err_wr = (addr == 6'h3E) ? 8'h00 : sat_inc(err_cnt);

    rd_word = 32'hDEAD_BEEF;
    err_nxt = err_wr;
    if (addr_hit)
      rd_word = (cmd == 2'b11) ? data : ext_word;
    else if (addr == 6'h3E)
      rd_word = {16'h0, err_wr, 7'h0, link_up};
    else if (addr == 6'h3F)
      rd_word = 32'h5349_4F31;
    else if (cmd[1])
      err_nxt = sat_inc(err_wr);
  end

  always_ff @(posedge c) begin
    if (r) begin
      state   <= DOWN;
      link_up <= 1'b0;
      cnt     <= '0;
      err_cnt <= 8'h00;
      rdata_r <= 32'h0;
      q       <= DEFAULTS;
      wstrobe <= '0;
    end else begin
      wstrobe <= '0;
      if (bus.wvalid) begin
        state   <= UP;
        link_up <= 1'b1;
        cnt     <= '0;
        err_cnt <= err_nxt;
        for (int k = 0; k < NREG; k++) begin
          if (cmd[0] && sel[k]) begin
            q[32*k +: 32] <= data;
            wstrobe[k]    <= 1'b1;
          end
        end
        if (cmd[1]) rdata_r <= rd_word;
      end else begin
        if (cnt != TMAX) cnt <= cnt + 1'b1;
        // Idle edge that brings cnt to TIMEOUT drops the link and restores defaults.
        if (state == UP && cnt == TLAST) begin
          state   <= DOWN;
          link_up <= 1'b0;
          q       <= DEFAULTS;
        end
      end
    end
  end

endmodule

// File: tb/tb_sio_target_regs.sv
// Randomized and directed bench for sio_target_regs against a cycle-level behavioural model.
module tb_sio_target_regs;
  localparam int NREG    = 8;
  localparam int TIMEOUT = 16;
  localparam logic [NREG*32-1:0] DEF = {32'hD000_0007, 32'hD000_0006, 32'hD000_0005,
                                        32'hD000_0004, 32'hD000_0003, 32'hD000_0002,
                                        32'hD000_0001, 32'hD000_0000};

  logic c = 1'b0;
  logic r = 1'b0;
  logic [32*NREG-1:0] ext;
  logic [32*NREG-1:0] q;
  logic [NREG-1:0]    wstrobe;
  logic               link_up;

  always #5 c = ~c;

  sio_target_regs_if bus();

  sio_target_regs #(.NREG(NREG), .TIMEOUT(TIMEOUT), .DEFAULTS(DEF)) dut (
    .c(c), .r(r), .bus(bus), .ext(ext), .q(q), .wstrobe(wstrobe), .link_up(link_up)
  );

  // Behavioural model state
  logic [31:0]     mq [NREG];
  logic [31:0]     mrd;
  int              merr;
  bit              mlink;
  int              midle;
  logic [NREG-1:0] mstb;

  int checks   = 0;
  int failures = 0;

  function automatic logic [39:0] word(input logic [1:0] cmd, input logic [5:0] a,
                                       input logic [31:0] d);
    return {cmd, a, d};
  endfunction

  function automatic logic [32*NREG-1:0] mflat();
    logic [32*NREG-1:0] v;
    for (int k = 0; k < NREG; k++) v[32*k +: 32] = mq[k];
    return v;
  endfunction

  task automatic model_edge(input logic rr, input logic wv, input logic [39:0] w);
    logic [1:0]  cmd;
    int          a;
    logic [31:0] d;
    logic [31:0] ev;
    cmd  = w[39:38];
    a    = int'(w[37:32]);
    d    = w[31:0];
    mstb = '0;
    if (rr) begin
      for (int k = 0; k < NREG; k++) mq[k] = DEF[32*k +: 32];
      mrd   = 32'h0;
      merr  = 0;
      mlink = 1'b0;
      midle = 0;
    end else if (wv) begin
      if (cmd[0]) begin
        if (a < NREG) begin
          for (int k = 0; k < NREG; k++)
            if (k == a) begin mq[k] = d; mstb[k] = 1'b1; end
        end else if (a == 62) merr = 0;
        else merr = (merr < 255) ? merr + 1 : 255;
      end
      if (cmd[1]) begin
        if (a < NREG) begin
          ev = 32'h0;
          for (int k = 0; k < NREG; k++) if (k == a) ev = ext[32*k +: 32];
          mrd = (cmd == 2'b11) ? d : ev;
        end else if (a == 62) mrd = {16'h0, 8'(merr), 7'h0, mlink};
        else if (a == 63) mrd = 32'h5349_4F31;
        else begin
          mrd  = 32'hDEAD_BEEF;
          merr = (merr < 255) ? merr + 1 : 255;
        end
      end
      mlink = 1'b1;
      midle = 0;
    end else begin
      midle++;
      if (mlink && midle == TIMEOUT) begin
        mlink = 1'b0;
        for (int k = 0; k < NREG; k++) mq[k] = DEF[32*k +: 32];
      end
    end
  endtask

  task automatic step(input logic rr, input logic wv, input logic [39:0] w);
    r          = rr;
    bus.wvalid = wv;
    bus.wdata  = w;
    @(posedge c);
    model_edge(rr, wv, w);
    #1;
    r          = 1'b0;
    bus.wvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 40'h0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 40'h0);
    checks++; if (q !== DEF) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, DEF); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL reset_link got=%b exp=0", link_up); end
    checks++; if (wstrobe !== 8'h00) begin failures++; $display("FAIL reset_wstrobe got=%h exp=00", wstrobe); end
  endtask

  task automatic test_write();
    step(1'b0, 1'b1, word(2'b01, 6'd2, 32'h1234_5678));
    checks++; if (q[95:64] !== 32'h1234_5678) begin failures++; $display("FAIL write_q2 got=%h exp=12345678", q[95:64]); end
    checks++; if (wstrobe !== 8'h04) begin failures++; $display("FAIL write_strobe got=%h exp=04", wstrobe); end
    checks++; if (link_up !== 1'b1) begin failures++; $display("FAIL write_link got=%b exp=1", link_up); end
    idle(1);
    checks++; if (wstrobe !== 8'h00) begin failures++; $display("FAIL write_strobe_drop got=%h exp=00", wstrobe); end
    checks++; if (q[95:64] !== 32'h1234_5678) begin failures++; $display("FAIL write_q2_hold got=%h exp=12345678", q[95:64]); end
  endtask

  task automatic test_read();
    ext[127:96] = 32'hCAFE_0003;
    step(1'b0, 1'b1, word(2'b10, 6'd3, 32'h0));
    checks++; if (bus.rdata !== 32'hCAFE_0003) begin failures++; $display("FAIL read_ext3 got=%h exp=cafe0003", bus.rdata); end
    step(1'b0, 1'b1, word(2'b00, 6'd4, 32'h0));
    idle(2);
    checks++; if (bus.rdata !== 32'hCAFE_0003) begin failures++; $display("FAIL read_hold_nop got=%h exp=cafe0003", bus.rdata); end
    step(1'b0, 1'b1, word(2'b10, 6'h3F, 32'h0));
    checks++; if (bus.rdata !== 32'h5349_4F31) begin failures++; $display("FAIL read_id got=%h exp=53494f31", bus.rdata); end
    step(1'b0, 1'b1, word(2'b11, 6'd5, 32'h0BAD_F00D));
    checks++; if (bus.rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL wr_rd_data got=%h exp=0badf00d", bus.rdata); end
    checks++; if (wstrobe !== 8'h20) begin failures++; $display("FAIL wr_rd_strobe got=%h exp=20", wstrobe); end
  endtask

  task automatic test_errors();
    step(1'b0, 1'b1, word(2'b01, 6'h3E, 32'h1234));
    checks++; if (wstrobe !== 8'h00) begin failures++; $display("FAIL errclr_strobe got=%h exp=00", wstrobe); end
    step(1'b0, 1'b1, word(2'b01, 6'd9, 32'h1));
    checks++; if (q !== mflat()) begin failures++; $display("FAIL bad_write_q got=%h exp=%h", q, mflat()); end
    step(1'b0, 1'b1, word(2'b10, 6'h3E, 32'h0));
    checks++; if (bus.rdata !== 32'h0000_0101) begin failures++; $display("FAIL err_one got=%h exp=00000101", bus.rdata); end
    step(1'b0, 1'b1, word(2'b10, 6'h3C, 32'h0));
    checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bad_read got=%h exp=deadbeef", bus.rdata); end
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, word(2'b01, 6'(9 + (i % 20)), 32'(i)));
    step(1'b0, 1'b1, word(2'b10, 6'h3E, 32'h0));
    checks++; if (bus.rdata !== 32'h0000_FF01) begin failures++; $display("FAIL err_sat got=%h exp=0000ff01", bus.rdata); end
    step(1'b0, 1'b1, word(2'b01, 6'h3E, 32'h0));
    step(1'b0, 1'b1, word(2'b10, 6'h3E, 32'h0));
    checks++; if (bus.rdata !== 32'h0000_0001) begin failures++; $display("FAIL err_clear got=%h exp=00000001", bus.rdata); end
  endtask

  task automatic test_watchdog();
    step(1'b0, 1'b1, word(2'b01, 6'd0, 32'h1));
    idle(TIMEOUT - 1);
    checks++; if (link_up !== 1'b1) begin failures++; $display("FAIL wd_before got=%b exp=1", link_up); end
    checks++; if (q[31:0] !== 32'h1) begin failures++; $display("FAIL wd_q0_before got=%h exp=1", q[31:0]); end
    idle(1);
    checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL wd_down got=%b exp=0", link_up); end
    checks++; if (q !== DEF) begin failures++; $display("FAIL wd_defaults got=%h exp=%h", q, DEF); end
    checks++; if (wstrobe !== 8'h00) begin failures++; $display("FAIL wd_strobe got=%h exp=00", wstrobe); end
    step(1'b0, 1'b1, word(2'b01, 6'd0, 32'h1));
    idle(TIMEOUT - 1);
    step(1'b0, 1'b1, word(2'b00, 6'd0, 32'h0));
    checks++; if (link_up !== 1'b1) begin failures++; $display("FAIL wd_keep_up got=%b exp=1", link_up); end
    checks++; if (q[31:0] !== 32'h1) begin failures++; $display("FAIL wd_keep_q0 got=%h exp=1", q[31:0]); end
  endtask

  task automatic test_reset_override();
    step(1'b0, 1'b1, word(2'b11, 6'd1, 32'h7777_0001));
    step(1'b1, 1'b1, word(2'b11, 6'd1, 32'hA5A5_A5A5));
    checks++; if (q !== DEF) begin failures++; $display("FAIL rst_ovr_q got=%h exp=%h", q, DEF); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rst_ovr_rdata got=%h exp=0", bus.rdata); end
    checks++; if (wstrobe !== 8'h00 || link_up !== 1'b0) begin
      failures++; $display("FAIL rst_ovr_ctrl got=%h/%b exp=00/0", wstrobe, link_up);
    end
  endtask

  task automatic test_random(input int n, input int wv_div);
    logic [1:0]  cmd;
    logic [5:0]  a;
    int          pick;
    logic        wv;
    logic        rr;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) ext[32*$urandom_range(0, NREG-1) +: 32] = $urandom;
      pick = $urandom_range(0, 11);
      a    = (pick < NREG) ? 6'(pick) : (pick == 8) ? 6'd9 : (pick == 9) ? 6'h3E :
             (pick == 10) ? 6'h3F : 6'($urandom);
      cmd  = 2'($urandom);
      if (cmd == 2'b11 && a >= 6'(NREG)) cmd = 2'b10;
      wv   = ($urandom_range(0, wv_div - 1) == 0);
      rr   = ($urandom_range(0, 149) == 0);
      step(rr, wv, word(cmd, a, $urandom));
      checks++; if (q !== mflat()) begin failures++; $display("FAIL rnd_q i=%0d got=%h exp=%h", i, q, mflat()); end
      checks++; if (bus.rdata !== mrd) begin failures++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, bus.rdata, mrd); end
      checks++; if (wstrobe !== mstb) begin failures++; $display("FAIL rnd_strobe i=%0d got=%h exp=%h", i, wstrobe, mstb); end
      checks++; if (link_up !== mlink) begin failures++; $display("FAIL rnd_link i=%0d got=%b exp=%b", i, link_up, mlink); end
    end
  endtask

  initial begin
    bus.wvalid = 1'b0;
    bus.wdata  = 40'h0;
    for (int k = 0; k < NREG; k++) ext[32*k +: 32] = $urandom;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_watchdog();
    test_reset_override();
    test_random(400, 3);
    test_random(400, 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
